p4_router_egr_demux: RTL
========================

P4_ROUTER_EGR_DEMUX -- requirements
Module: p4_router_egr_demux

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of egress physical ports, range 1..16.
REQ-002 SHALL have parameter DATA_BYTES, default 8: AXIS data width in bytes on input and on every output.
REQ-003 SHALL have parameter PORT_ID_WIDTH, default 4: width of the egress-port field carried in in_tuser; must be >= $clog2(NUM_PORTS).
REQ-004 SHALL have port clk, input, 1: single clock; all logic runs in this domain.
REQ-005 SHALL have port areset, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have ports in_tdata / in_tkeep, input, DATA_BYTES*8 / DATA_BYTES: pipeline output beat.
REQ-007 SHALL have ports in_tvalid / in_tlast, input, 1 each; in_tready, output, 1.
REQ-008 SHALL have port in_tuser, input, PORT_ID_WIDTH: egress port ID, sampled only on the first beat of a packet.
REQ-009 SHALL have ports out_tdata / out_tkeep, output, DATA_BYTES*8 / DATA_BYTES: shared output register, broadcast to all ports.
REQ-010 SHALL have ports out_tvalid / out_tlast, output, NUM_PORTS each; out_tready, input, NUM_PORTS: per-port handshake.
REQ-011 SHALL have port drop_pulse, output, 1: one-cycle pulse for each dropped packet.
REQ-012 SHALL have port drop_count, output, 16: saturating count of dropped packets.

Function
REQ-013 SHALL implement a state machine with states SOF, FWD and DROP; SOF means the next accepted beat is a packet's first beat.
REQ-014 SHALL, in SOF on an accepted beat with in_tuser < NUM_PORTS, latch in_tuser as dst, forward the beat, and go to FWD; if in_tlast=1, SHALL stay in SOF.
REQ-015 SHALL, in SOF on an accepted beat with in_tuser >= NUM_PORTS, discard the beat and go to DROP; if in_tlast=1, SHALL stay in SOF and drop the packet immediately.
REQ-016 SHALL, in FWD, route every beat to the latched dst and ignore in_tuser; an accepted in_tlast SHALL return the state to SOF.
REQ-017 SHALL, in DROP, hold in_tready=1 and discard beats; an accepted in_tlast SHALL return the state to SOF.
REQ-018 SHALL hold forwarded beats in one output register (data, keep, last, valid, odst); latency from in handshake to out_tvalid SHALL be exactly 1 cycle.
REQ-019 SHALL drive out_tvalid[i] = valid_reg && (odst==i); out_tlast[i] = last_reg && (odst==i).
REQ-020 SHALL drive in_tready = !valid_reg || out_tready[odst] in SOF/FWD, with no dependency on in_tvalid; in DROP the value is per REQ-017.
REQ-021 SHALL drop valid_reg when the selected port accepts the beat and no new beat loads; a simultaneous accept and load SHALL replace the register contents with no bubble, including when the new beat targets a different port.
REQ-022 SHALL hold out_tdata, out_tkeep, out_tlast and odst stable while valid_reg=1 and out_tready[odst]=0.
REQ-023 SHALL ignore out_tready of non-selected ports.
REQ-024 SHALL assert drop_pulse for one cycle in the cycle after the dropped packet's in_tlast is accepted.
REQ-025 SHALL increment drop_count on each drop_pulse and saturate at 0xFFFF with no wrap.
REQ-026 SHALL pass in_tkeep unmodified; no packet shall be truncated, merged or reordered.

Reset
REQ-027 SHALL, while areset=1 (asynchronously), force state=SOF, valid_reg=0, out_tvalid=0, out_tlast=0, in_tready=0, drop_pulse=0, drop_count=0, dst=0, odst=0.
REQ-028 SHALL discard any partial packet in flight when reset asserts mid-packet; the first beat after release is treated as SOF.
REQ-029 SHALL drive in_tready=1 in the first cycle after release (output register empty).

Verification
REQ-030 SHALL cover: NUM_PORTS=4, 3-beat packet with tuser=2, all out_tready=1 -> out_tvalid=4'b0100 for 3 consecutive cycles, each 1 cycle after input; out_tlast[2] on beat 3.
REQ-031 SHALL cover: packet with tuser=5 (invalid), 4 beats -> no out_tvalid, in_tready=1 throughout, drop_pulse once, drop_count=1.
REQ-032 SHALL cover: back-to-back 1-beat packets to ports 0,1,3 with continuous in_tvalid -> three output beats on consecutive cycles to 0,1,3 with no bubble.
REQ-033 SHALL cover: out_tready[1]=0 for 5 cycles mid-packet to port 1 -> in_tready=0, out_tdata stable, no beat lost or duplicated after release; toggling out_tready[0] has no effect.
REQ-034 SHALL cover: tuser changed to 0 on beats 2..N of a port-3 packet -> all beats delivered on port 3.
REQ-035 SHALL cover: areset asserted mid-packet in FWD, then released, then a new packet to port 1 -> outputs zero during reset and the new packet is delivered intact on port 1; also drop_count preloaded near saturation plus 2 drops -> holds 0xFFFF.

Source files
------------

// File: rtl/p4_router_egr_demux.sv
// Egress demultiplexer for the P4 router pipeline.
// Beats arrive on one AXI-Stream input. The egress port is taken from in_tuser
// on the first beat of each packet, and every beat of that packet goes out on
// that port. Packets whose port ID is out of range are swallowed and counted.
// One shared output register carries each forwarded beat. Its data and keep are
// broadcast to all ports, and only the selected port sees tvalid and tlast.
module p4_router_egr_demux #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_BYTES    = 8,
  parameter int PORT_ID_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       areset,
  // pipeline side
  input  logic [DATA_BYTES*8-1:0]    in_tdata,
  input  logic [DATA_BYTES-1:0]      in_tkeep,
  input  logic                       in_tvalid,
  input  logic                       in_tlast,
  input  logic [PORT_ID_WIDTH-1:0]   in_tuser,
  output logic                       in_tready,
  // egress side
  output logic [DATA_BYTES*8-1:0]    out_tdata,
  output logic [DATA_BYTES-1:0]      out_tkeep,
  output logic [NUM_PORTS-1:0]       out_tvalid,
  output logic [NUM_PORTS-1:0]       out_tlast,
  input  logic [NUM_PORTS-1:0]       out_tready,
  // drop statistics
  output logic                       drop_pulse,
  output logic [15:0]                drop_count
);

  localparam int          ODST_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] NUM_PORTS_U = NUM_PORTS;

  typedef enum logic [1:0] {
    ST_SOF  = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_next_s;
  logic [ODST_W-1:0]         dst_r;
  logic [ODST_W-1:0]         dst_next_s;

  // output register
  logic                      valid_r;
  logic                      last_r;
  logic [DATA_BYTES*8-1:0]   data_r;
  logic [DATA_BYTES-1:0]     keep_r;
  logic [ODST_W-1:0]         odst_r;

  logic                      drop_pulse_r;
  logic [15:0]               drop_count_r;

  logic                      ready_s;
  logic                      in_fire_s;
  logic                      tuser_ok_s;
  logic                      out_accept_s;
  logic                      load_s;
  logic [ODST_W-1:0]         load_dst_s;
  logic                      drop_event_s;

  // The port ID is widened before it is compared, so a full-width field still
  // compares correctly against NUM_PORTS.
  assign tuser_ok_s   = (32'(in_tuser) < NUM_PORTS_U);

  // Only the selected port's tready matters. The other ports are never looked at.
  assign out_accept_s = valid_r & out_tready[odst_r];

  // The ready signal depends only on registered state and the selected port's
  // tready, and never on in_tvalid. While a packet is being dropped, beats are
  // taken freely because nothing is written into the output register.
  assign ready_s   = !areset && ((state_r == ST_DROP) || !valid_r || out_tready[odst_r]);
  assign in_fire_s = in_tvalid && ready_s;
  assign in_tready = ready_s;

  // Packet framing state and latched destination
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r <= ST_SOF;
      dst_r   <= '0;
    end else begin
      state_r <= state_next_s;
      dst_r   <= dst_next_s;
    end
  end

  // Next-state logic, load decision and drop detection
  always_comb begin
    state_next_s = state_r;
    dst_next_s   = dst_r;
    load_s       = 1'b0;
    load_dst_s   = dst_r;
    drop_event_s = 1'b0;
    case (state_r)
      ST_SOF: begin
        if (in_fire_s) begin
          if (tuser_ok_s) begin
            load_s       = 1'b1;
            load_dst_s   = in_tuser[ODST_W-1:0];
            dst_next_s   = in_tuser[ODST_W-1:0];
            state_next_s = in_tlast ? ST_SOF : ST_FWD;
          end else begin
            // A one-beat bad packet is dropped at once and never enters DROP.
            drop_event_s = in_tlast;
            state_next_s = in_tlast ? ST_SOF : ST_DROP;
          end
        end else begin
          state_next_s = ST_SOF;
        end
      end
      ST_FWD: begin
        if (in_fire_s) begin
          // in_tuser is ignored after the first beat.
          load_s       = 1'b1;
          load_dst_s   = dst_r;
          state_next_s = in_tlast ? ST_SOF : ST_FWD;
        end else begin
          state_next_s = ST_FWD;
        end
      end
      ST_DROP: begin
        if (in_fire_s) begin
          drop_event_s = in_tlast;
          state_next_s = in_tlast ? ST_SOF : ST_DROP;
        end else begin
          state_next_s = ST_DROP;
        end
      end
      default: begin
        state_next_s = ST_SOF;
      end
    endcase
  end

  // Shared output register. A new beat may replace one that is being accepted
  // in the same cycle, even if it goes to another port, so no bubble appears.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= '0;
      keep_r  <= '0;
      odst_r  <= '0;
    end else if (load_s) begin
      valid_r <= 1'b1;
      last_r  <= in_tlast;
      data_r  <= in_tdata;
      keep_r  <= in_tkeep;
      odst_r  <= load_dst_s;
    end else if (out_accept_s) begin
      valid_r <= 1'b0;
    end
  end

  // Drop pulse one cycle after the bad packet's last beat, with a saturating count
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      drop_pulse_r <= 1'b0;
      drop_count_r <= 16'h0000;
    end else begin
      drop_pulse_r <= drop_event_s;
      if (drop_event_s && (drop_count_r != 16'hFFFF)) begin
        drop_count_r <= drop_count_r + 16'h0001;
      end
    end
  end

  // Decode the output register onto the per-port valid and last lines
  always_comb begin
    out_tvalid = '0;
    out_tlast  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      out_tvalid[i] = valid_r && (odst_r == ODST_W'(i));
      out_tlast[i]  = valid_r && last_r && (odst_r == ODST_W'(i));
    end
  end

  assign out_tdata  = data_r;
  assign out_tkeep  = keep_r;
  assign drop_pulse = drop_pulse_r;
  assign drop_count = drop_count_r;

endmodule
